regfile_bp: RTL and testbench

Parametrised successor to the team's two-read/one-write register file, used as the CPU datapath register bank. Generalises data width and depth, and adds four features:
- per-byte write enables;
- an optional hardwired zero register;
- write-to-read bypass (write-first);
- a sequential clear engine that zeroes every entry after reset or on request, with a busy flag the pipeline stalls on.

---
 rtl/regfile_bp.sv | 108 ++++++++++
 tb/tb_regfile_bp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_bp.sv
// Two-read/one-write register bank with byte enables, optional zero register,
// write-first bypass and a sequential clear engine that stalls via busy.
module regfile_bp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    output logic               busy
);

    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic wa_ok;
    logic wr_ok;
    logic [WIDTH-1:0] merged;

    assign busy  = (state == CLEAR);
    assign wa_ok = ({1'b0, wa} < DEPTH_W) && !(ZERO_REG != 0 && wa == '0);
    assign wr_ok = (state == READY) && we && !clr && wa_ok;

    always_comb begin
        merged = '0;
        if (wa_ok) merged = mem[wa];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            CLEAR: begin
                if (idx == LAST) state_nx = READY;
                else idx_nx = idx + 1'b1;
            end
            READY: begin
                if (clr) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Clear sweep owns the write port; user writes only land when READY.
    always_ff @(posedge clk) begin
        if (rst) mem[0] <= '0;
        else if (state == CLEAR) mem[idx] <= '0;
        else if (wr_ok) mem[wa] <= merged;
    end

    function automatic logic [WIDTH-1:0] rd_sel(
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] word,
        input logic             bsy,
        input logic             wok,
        input logic [AW-1:0]    waddr,
        input logic [WIDTH-1:0] mrg
    );
        logic [WIDTH-1:0] r;
        r = '0;
        if (bsy) r = '0;
        else if (ZERO_REG != 0 && ra == '0) r = '0;
        else if ({1'b0, ra} >= DEPTH_W) r = '0;
        else if (BYPASS != 0 && wok && ra == waddr) r = mrg;
        else r = word;
        return r;
    endfunction

    assign rd1 = rd_sel(ra1, mem[ra1], busy, wr_ok, wa, merged);
    assign rd2 = rd_sel(ra2, mem[ra2], busy, wr_ok, wa, merged);

endmodule

// File: tb/tb_regfile_bp.sv
// Bench for regfile_bp: vector table through a scoreboard queue plus
// hand-written reset / clear sweep sequences.
module tb_regfile_bp;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [4:0]  ra1, ra2, wa;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    regfile_bp dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ra1 (ra1),
        .ra2 (ra2),
        .we  (we),
        .wa  (wa),
        .be  (be),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic apply(input string nm, input vec_t v);
        exp_t e;
        we  = v.we;
        wa  = v.wa;
        be  = v.be;
        wd  = v.wd;
        ra1 = v.ra1;
        ra2 = v.ra2;
        sb.push_back('{nm, v.e1, v.e2});
        @(negedge clk);
        e = sb.pop_front();
        check({e.name, "_rd1"}, rd1, e.e1);
        check({e.name, "_rd2"}, rd2, e.e2);
        step();
    endtask

    task automatic count_busy(output int n, output int nz);
        n  = 0;
        nz = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) nz++;
        end
    endtask

    initial begin
        int n, nz;
        vec_t v;

        tbl[0]  = '{1, 1, 4'hF, 32'h55555555, 1, 2, 32'h55555555, 32'h0};
        tbl[1]  = '{0, 0, 4'h0, 32'h0, 1, 1, 32'h55555555, 32'h55555555};
        tbl[2]  = '{1, 1, 4'h5, 32'hAAAAAAAA, 2, 1, 32'h0, 32'h55AA55AA};
        tbl[3]  = '{0, 0, 4'h0, 32'h0, 1, 1, 32'h55AA55AA, 32'h55AA55AA};
        tbl[4]  = '{1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h0};
        tbl[5]  = '{0, 0, 4'h0, 32'h0, 0, 1, 32'h0, 32'h55AA55AA};
        tbl[6]  = '{1, 3, 4'hF, 32'h12345678, 3, 4, 32'h12345678, 32'h0};
        tbl[7]  = '{1, 4, 4'h0, 32'hFFFFFFFF, 4, 3, 32'h0, 32'h12345678};
        tbl[8]  = '{1, 31, 4'h8, 32'hDEADBEEF, 31, 30, 32'hDE000000, 32'h0};
        tbl[9]  = '{1, 30, 4'h2, 32'h0000AB00, 31, 30, 32'hDE000000, 32'h0000AB00};
        tbl[10] = '{0, 0, 4'h0, 32'h0, 30, 3, 32'h0000AB00, 32'h12345678};
        tbl[11] = '{0, 0, 4'h0, 32'h0, 7, 5, 32'h0, 32'h0};

        rst = 1'b1;
        clr = 1'b0;
        we  = 1'b0;
        wa  = '0;
        be  = '0;
        wd  = '0;
        ra1 = 5'd5;
        ra2 = 5'd7;
        step();
        step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        step();

        // Sweep after reset with a write and clr held: both must be ignored.
        rst = 1'b0;
        clr = 1'b1;
        we  = 1'b1;
        wa  = 5'd7;
        be  = 4'hF;
        wd  = 32'hFFFFFFFF;
        count_busy(n, nz);
        clr = 1'b0;
        we  = 1'b0;
        check("rst_sweep_cycles", 32'(n), 32'd32);
        check("rst_sweep_reads", 32'(nz), 32'd0);
        step();

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // clr together with a write: write dropped, no bypass this cycle.
        clr = 1'b1;
        we  = 1'b1;
        wa  = 5'd4;
        be  = 4'hF;
        wd  = 32'h1;
        ra1 = 5'd3;
        ra2 = 5'd4;
        @(negedge clk);
        check("clr_cyc_rd1", rd1, 32'h12345678);
        check("clr_cyc_rd2", rd2, 32'h0);
        step();
        clr = 1'b0;
        we  = 1'b0;
        count_busy(n, nz);
        check("clr_sweep_edges", 32'(n + 1), 32'd33);
        check("clr_sweep_reads", 32'(nz), 32'd0);
        step();
        v = '{0, 0, 4'h0, 32'h0, 3, 4, 32'h0, 32'h0};
        apply("post_clr", v);
        v = '{0, 0, 4'h0, 32'h0, 31, 30, 32'h0, 32'h0};
        apply("post_clr_hi", v);

        // rst at sweep index 10 restarts the sweep from 0.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'h1);
        step();
        rst = 1'b0;
        count_busy(n, nz);
        check("mid_rst_sweep", 32'(n), 32'd32);
        step();
        v = '{1, 2, 4'hF, 32'hCAFEF00D, 2, 2, 32'hCAFEF00D, 32'hCAFEF00D};
        apply("after_rst_wr", v);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
